// File: rtl/pe_sequencer.sv
// Control sequencer for one processing element: streams a filter row and an
// ifmap row into the PE scratchpads, issues the 1-D convolution MACs and drains psums.
module pe_sequencer #(
   parameter int FADDR_W  = 6,
   parameter int IADDR_W  = 4,
   parameter int PIPE_LAT = 3,
   parameter int RD_LAT   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [4:0]         cfg_s,
   input  logic [4:0]         cfg_w,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               load_filter,
   output logic               load_ifmap,
   output logic [FADDR_W-1:0] ld_addr_filter,
   output logic [IADDR_W-1:0] ld_addr_ifmap,
   output logic [7:0]         filter,
   output logic [7:0]         ifmap,
   output logic [FADDR_W-1:0] sel_filter_addr,
   output logic [IADDR_W-1:0] sel_ifmap_addr,
   output logic [IADDR_W-1:0] psum_sel,
   output logic               en,
   output logic               en_psum_out,
   input  logic [7:0]         pe_psum,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               done,
   output logic               cfg_err
);

   typedef enum logic [3:0] {
      IDLE, LD_FILT, LD_IFMAP, COMPUTE, FLUSH,
      DRAIN_REQ, DRAIN_WAIT, DRAIN_OUT, DONE
   } state_t;

   localparam logic [4:0] PIPE_V = 5'(PIPE_LAT);
   localparam logic [4:0] RDW_V  = 5'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

   state_t state, state_n;
   logic [4:0] s_len, s_len_n, w_len, w_len_n, e_len, e_len_n;
   logic [4:0] s_cnt, s_cnt_n, e_cnt, e_cnt_n, k_cnt, k_cnt_n, wait_cnt, wait_n;

   logic               in_ready_n, load_filter_n, load_ifmap_n;
   logic [FADDR_W-1:0] ld_addr_filter_n, sel_filter_addr_n;
   logic [IADDR_W-1:0] ld_addr_ifmap_n, sel_ifmap_addr_n, psum_sel_n;
   logic [7:0]         filter_n, ifmap_n, out_data_n;
   logic               en_n, en_psum_out_n, out_valid_n, busy_n, done_n, cfg_err_n;

   // State, counters and every output are registered together, so each output
   // reflects the state being entered on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         s_len           <= '0;
         w_len           <= '0;
         e_len           <= '0;
         s_cnt           <= '0;
         e_cnt           <= '0;
         k_cnt           <= '0;
         wait_cnt        <= '0;
         in_ready        <= 1'b0;
         load_filter     <= 1'b0;
         load_ifmap      <= 1'b0;
         ld_addr_filter  <= '0;
         ld_addr_ifmap   <= '0;
         filter          <= '0;
         ifmap           <= '0;
         sel_filter_addr <= '0;
         sel_ifmap_addr  <= '0;
         psum_sel        <= '0;
         en              <= 1'b0;
         en_psum_out     <= 1'b0;
         out_data        <= '0;
         out_valid       <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         cfg_err         <= 1'b0;
      end else begin
         state           <= state_n;
         s_len           <= s_len_n;
         w_len           <= w_len_n;
         e_len           <= e_len_n;
         s_cnt           <= s_cnt_n;
         e_cnt           <= e_cnt_n;
         k_cnt           <= k_cnt_n;
         wait_cnt        <= wait_n;
         in_ready        <= in_ready_n;
         load_filter     <= load_filter_n;
         load_ifmap      <= load_ifmap_n;
         ld_addr_filter  <= ld_addr_filter_n;
         ld_addr_ifmap   <= ld_addr_ifmap_n;
         filter          <= filter_n;
         ifmap           <= ifmap_n;
         sel_filter_addr <= sel_filter_addr_n;
         sel_ifmap_addr  <= sel_ifmap_addr_n;
         psum_sel        <= psum_sel_n;
         en              <= en_n;
         en_psum_out     <= en_psum_out_n;
         out_data        <= out_data_n;
         out_valid       <= out_valid_n;
         busy            <= busy_n;
         done            <= done_n;
         cfg_err         <= cfg_err_n;
      end
   end

   // Next-state logic; wait_cnt is shared by the hazard gap, the flush and the read wait.
   always_comb begin
      state_n           = state;
      s_len_n           = s_len;
      w_len_n           = w_len;
      e_len_n           = e_len;
      s_cnt_n           = s_cnt;
      e_cnt_n           = e_cnt;
      k_cnt_n           = k_cnt;
      wait_n            = wait_cnt;
      load_filter_n     = 1'b0;
      load_ifmap_n      = 1'b0;
      ld_addr_filter_n  = '0;
      ld_addr_ifmap_n   = '0;
      filter_n          = '0;
      ifmap_n           = '0;
      sel_filter_addr_n = '0;
      sel_ifmap_addr_n  = '0;
      psum_sel_n        = '0;
      en_n              = 1'b0;
      en_psum_out_n     = 1'b0;
      out_data_n        = out_data;
      cfg_err_n         = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if (cfg_s != 5'd0 && cfg_s <= cfg_w && cfg_w <= 5'd16) begin
                  s_len_n = cfg_s;
                  w_len_n = cfg_w;
                  e_len_n = cfg_w - cfg_s + 5'd1;
                  k_cnt_n = '0;
                  state_n = LD_FILT;
               end else begin
                  cfg_err_n = 1'b1;
               end
            end
         end
         LD_FILT: begin
            if (in_valid && in_ready) begin
               load_filter_n    = 1'b1;
               ld_addr_filter_n = FADDR_W'(k_cnt);
               filter_n         = in_data;
               if (k_cnt == s_len - 5'd1) begin
                  k_cnt_n = '0;
                  state_n = LD_IFMAP;
               end else begin
                  k_cnt_n = k_cnt + 5'd1;
               end
            end
         end
         LD_IFMAP: begin
            if (in_valid && in_ready) begin
               load_ifmap_n    = 1'b1;
               ld_addr_ifmap_n = IADDR_W'(k_cnt);
               ifmap_n         = in_data;
               if (k_cnt == w_len - 5'd1) begin
                  k_cnt_n = '0;
                  s_cnt_n = '0;
                  e_cnt_n = '0;
                  wait_n  = '0;
                  state_n = COMPUTE;
               end else begin
                  k_cnt_n = k_cnt + 5'd1;
               end
            end
         end
         COMPUTE: begin
            if (wait_cnt != 5'd0) begin
               wait_n = wait_cnt - 5'd1;
            end else begin
               en_n              = 1'b1;
               sel_filter_addr_n = FADDR_W'(s_cnt);
               sel_ifmap_addr_n  = IADDR_W'(e_cnt + s_cnt);
               psum_sel_n        = IADDR_W'(e_cnt);
               if (e_cnt != e_len - 5'd1) begin
                  e_cnt_n = e_cnt + 5'd1;
               end else begin
                  e_cnt_n = '0;
                  if (s_cnt == s_len - 5'd1) begin
                     wait_n  = PIPE_V - 5'd1;
                     state_n = FLUSH;
                  end else begin
                     s_cnt_n = s_cnt + 5'd1;
                     // Short rows would revisit a psum before its write-back lands.
                     if (e_len < PIPE_V) wait_n = PIPE_V - e_len;
                  end
               end
            end
         end
         FLUSH: begin
            if (wait_cnt != 5'd0) begin
               wait_n = wait_cnt - 5'd1;
            end else begin
               e_cnt_n       = '0;
               en_psum_out_n = 1'b1;
               psum_sel_n    = '0;
               state_n       = DRAIN_REQ;
            end
         end
         DRAIN_REQ: begin
            if (RD_LAT > 1) begin
               wait_n  = RDW_V;
               state_n = DRAIN_WAIT;
            end else begin
               out_data_n = pe_psum;
               state_n    = DRAIN_OUT;
            end
         end
         DRAIN_WAIT: begin
            if (wait_cnt != 5'd0) begin
               wait_n = wait_cnt - 5'd1;
            end else begin
               out_data_n = pe_psum;
               state_n    = DRAIN_OUT;
            end
         end
         DRAIN_OUT: begin
            if (out_valid && out_ready) begin
               if (e_cnt == e_len - 5'd1) begin
                  state_n = DONE;
               end else begin
                  e_cnt_n       = e_cnt + 5'd1;
                  en_psum_out_n = 1'b1;
                  psum_sel_n    = IADDR_W'(e_cnt + 5'd1);
                  state_n       = DRAIN_REQ;
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      in_ready_n  = (state_n == LD_FILT) || (state_n == LD_IFMAP);
      out_valid_n = (state_n == DRAIN_OUT);
      busy_n      = (state_n != IDLE);
      done_n      = (state_n == DONE);
   end

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer: a behavioural PE supplies pe_psum and a
// scoreboard of reference convolution results is compared against drained outputs.
module tb_pe_sequencer;

   localparam int PIPE_LAT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] cfg_s, cfg_w;
   logic [7:0] in_data;
   logic       in_valid, in_ready;
   logic       load_filter, load_ifmap;
   logic [5:0] ld_addr_filter, sel_filter_addr;
   logic [3:0] ld_addr_ifmap, sel_ifmap_addr, psum_sel;
   logic [7:0] filter, ifmap, pe_psum, out_data;
   logic       en, en_psum_out, out_valid, out_ready, busy, done, cfg_err;
   logic [56:0] all_out;

   always #5 clk = ~clk;

   pe_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .cfg_s(cfg_s), .cfg_w(cfg_w),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .load_filter(load_filter), .load_ifmap(load_ifmap),
      .ld_addr_filter(ld_addr_filter), .ld_addr_ifmap(ld_addr_ifmap),
      .filter(filter), .ifmap(ifmap),
      .sel_filter_addr(sel_filter_addr), .sel_ifmap_addr(sel_ifmap_addr),
      .psum_sel(psum_sel), .en(en), .en_psum_out(en_psum_out), .pe_psum(pe_psum),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   assign all_out = {in_ready, load_filter, load_ifmap, ld_addr_filter, ld_addr_ifmap,
                     filter, ifmap, sel_filter_addr, sel_ifmap_addr, psum_sel, en,
                     en_psum_out, out_data, out_valid, busy, done, cfg_err};

   int errors = 0;
   int checks = 0;
   logic [7:0] sbq [$];
   logic [7:0] fbeat [32];
   logic [7:0] ibeat [32];

   // Behavioural PE: psum read at issue, written back PIPE_LAT cycles after en rose.
   logic [7:0] fsp [64];
   logic [7:0] isp [16];
   logic [7:0] psum_arr [16];
   logic       st0_v, st1_v;
   logic [3:0] st0_a, st1_a;
   logic [7:0] st0_d, st1_d;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         st0_v   <= 1'b0;
         st1_v   <= 1'b0;
         pe_psum <= 8'd0;
      end else begin
         if (load_filter) fsp[ld_addr_filter] <= filter;
         if (load_ifmap) isp[ld_addr_ifmap] <= ifmap;
         st0_v <= en;
         st0_a <= psum_sel;
         st0_d <= psum_arr[psum_sel] + fsp[sel_filter_addr] * isp[sel_ifmap_addr];
         st1_v <= st0_v;
         st1_a <= st0_a;
         st1_d <= st0_d;
         if (start && !busy) begin
            for (int a = 0; a < 16; a++) psum_arr[a] <= 8'd0;
         end else if (st1_v) begin
            psum_arr[st1_a] <= st1_d;
         end
         if (en_psum_out) pe_psum <= psum_arr[psum_sel];
      end
   end

   // Activity logs gathered away from the active edge.
   int cyc = 0, en_cnt, done_cnt, err_cnt, busy_cnt, rdy_cnt, first_en, last_en;
   int         iss_c [$];
   logic [5:0] iss_f [$];
   logic [3:0] iss_i [$];
   logic [3:0] iss_p [$];
   logic [5:0] lf_a [$];
   logic [7:0] lf_d [$];
   logic [3:0] li_a [$];
   logic [7:0] li_d [$];

   always @(negedge clk) begin
      cyc++;
      if (load_filter) begin lf_a.push_back(ld_addr_filter); lf_d.push_back(filter); end
      if (load_ifmap) begin li_a.push_back(ld_addr_ifmap); li_d.push_back(ifmap); end
      if (en) begin
         if (first_en < 0) first_en = cyc;
         last_en = cyc;
         en_cnt++;
         iss_c.push_back(cyc);
         iss_f.push_back(sel_filter_addr);
         iss_i.push_back(sel_ifmap_addr);
         iss_p.push_back(psum_sel);
      end
      if (done) done_cnt++;
      if (cfg_err) err_cnt++;
      if (busy) busy_cnt++;
      if (in_ready) rdy_cnt++;
   end

   task automatic clear_logs();
      en_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; rdy_cnt = 0;
      first_en = -1; last_en = -1;
      iss_c.delete(); iss_f.delete(); iss_i.delete(); iss_p.delete();
      lf_a.delete(); lf_d.delete(); li_a.delete(); li_d.delete();
   endtask

   // Runs one job from a negedge: loads beats, drains outputs against the scoreboard.
   task automatic run_job(input int s, input int w, input bit rnd_in, input int hold, input bit poke);
      int fi, ii, budget, hold_left;
      bit fin, pv, pr, poked;
      logic [7:0] pd, exp_v;
      for (int e = 0; e <= w - s; e++) begin
         exp_v = 8'd0;
         for (int k = 0; k < s; k++) exp_v = exp_v + fbeat[k] * ibeat[e + k];
         sbq.push_back(exp_v);
      end
      clear_logs();
      start = 1'b1; cfg_s = 5'(s); cfg_w = 5'(w);
      @(negedge clk);
      start = 1'b0;
      fi = 0; ii = 0; budget = 0; hold_left = hold;
      fin = 1'b0; pv = 1'b0; pr = 1'b0; poked = 1'b0; pd = 8'd0;
      while (!fin && budget < 3000) begin
         if (pv && !pr) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== pd) begin
               errors++;
               $display("[TB] FAIL out_hold: got valid=%0b data=%0d required valid=1 data=%0d", out_valid, out_data, pd);
            end
         end
         if (poke && !poked && en) begin
            start = 1'b1; cfg_s = 5'd1; cfg_w = 5'd1; poked = 1'b1;
         end else begin
            start = 1'b0;
         end
         in_valid = rnd_in ? 1'($urandom_range(0, 1)) : 1'b1;
         if (fi < s) in_data = fbeat[fi];
         else if (ii < w) in_data = ibeat[ii];
         else in_valid = 1'b0;
         if (in_valid && in_ready) begin
            if (fi < s) fi++;
            else ii++;
         end
         if (out_valid && hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("[TB] FAIL psum_extra: got %0d required no output", out_data);
            end else begin
               exp_v = sbq.pop_front();
               if (out_data !== exp_v) begin
                  errors++;
                  $display("[TB] FAIL psum: got %0d required %0d", out_data, exp_v);
               end
            end
         end
         pv = out_valid; pr = out_ready; pd = out_data;
         if (done) fin = 1'b1;
         if (!fin) begin
            @(negedge clk);
            budget++;
         end
      end
      in_valid = 1'b0;
      start = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("[TB] FAIL job_timeout: got no done after %0d cycles required done", budget);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_after_done: got busy=%0b done=%0b required 0 0", busy, done);
      end
      @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("[TB] FAIL psum_missing: got %0d left required 0", sbq.size());
      end
      sbq.delete();
   endtask

   task automatic check_loads(input int s, input int w);
      int bad = 0;
      checks++;
      if (lf_a.size() != s) bad++;
      else for (int i = 0; i < s; i++) if (lf_a[i] !== 6'(i) || lf_d[i] !== fbeat[i]) bad++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL filter_loads: got %0d loads %0d bad required %0d clean", lf_a.size(), bad, s);
      end
      bad = 0;
      checks++;
      if (li_a.size() != w) bad++;
      else for (int i = 0; i < w; i++) if (li_a[i] !== 4'(i) || li_d[i] !== ibeat[i]) bad++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL ifmap_loads: got %0d loads %0d bad required %0d clean", li_a.size(), bad, w);
      end
   endtask

   task automatic test_reset();
      int n, guard;
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h required 0", all_out);
      end
      rst = 1'b1;
      @(negedge clk);
      start = 1'b1; cfg_s = 5'd3; cfg_w = 5'd8;
      @(negedge clk);
      start = 1'b0;
      n = 0; guard = 0;
      while (n < 6 && guard < 50) begin
         in_valid = 1'b1; in_data = 8'(n + 1);
         if (in_ready) n++;
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_load: got busy=%0b in_ready=%0b required 1 1", busy, in_ready);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %h required 0", all_out);
      end
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("[TB] FAIL reset_hold: got %h required 0", all_out);
      end
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) fbeat[i] = 8'(i + 1);
      for (int i = 0; i < 8; i++) ibeat[i] = 8'(i);
      run_job(3, 8, 1'b0, 0, 1'b0);
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL reset_rerun_done: got %0d required 1", done_cnt);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 3; i++) fbeat[i] = 8'(i + 1);
      for (int i = 0; i < 8; i++) ibeat[i] = 8'(i);
      run_job(3, 8, 1'b0, 0, 1'b0);
      check_loads(3, 8);
      checks++;
      if (en_cnt != 18) begin
         errors++;
         $display("[TB] FAIL basic_issues: got %0d required 18", en_cnt);
      end
      checks++;
      if (last_en - first_en + 1 != 18) begin
         errors++;
         $display("[TB] FAIL basic_compute_len: got %0d required 18", last_en - first_en + 1);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL basic_done: got %0d required 1", done_cnt);
      end
   endtask

   task automatic test_hazard();
      int viol = 0, gapbad = 0, ordbad = 0;
      for (int i = 0; i < 4; i++) fbeat[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 5; i++) ibeat[i] = 8'($urandom_range(0, 255));
      run_job(4, 5, 1'b0, 0, 1'b0);
      checks++;
      if (en_cnt != 8) begin
         errors++;
         $display("[TB] FAIL hazard_issues: got %0d required 8", en_cnt);
      end
      checks++;
      if (last_en - first_en + 1 != 11) begin
         errors++;
         $display("[TB] FAIL hazard_compute_len: got %0d required 11", last_en - first_en + 1);
      end
      for (int i = 0; i < iss_c.size(); i++)
         for (int j = i + 1; j < iss_c.size(); j++)
            if (iss_c[j] - iss_c[i] < PIPE_LAT && iss_p[j] == iss_p[i]) viol++;
      checks++;
      if (viol != 0) begin
         errors++;
         $display("[TB] FAIL hazard_reissue: got %0d violations required 0", viol);
      end
      for (int n = 1; n < iss_c.size(); n++)
         if (iss_c[n] - iss_c[n - 1] - 1 != ((n % 2 == 0) ? 1 : 0)) gapbad++;
      checks++;
      if (gapbad != 0) begin
         errors++;
         $display("[TB] FAIL hazard_gaps: got %0d bad gaps required 0", gapbad);
      end
      for (int n = 0; n < iss_c.size(); n++)
         if (iss_f[n] !== 6'(n / 2) || iss_p[n] !== 4'(n % 2) || iss_i[n] !== 4'(n / 2 + n % 2)) ordbad++;
      checks++;
      if (ordbad != 0) begin
         errors++;
         $display("[TB] FAIL hazard_order: got %0d bad issues required 0", ordbad);
      end
   endtask

   task automatic test_invalid();
      int cs [3] = '{0, 6, 3};
      int cw [3] = '{5, 5, 17};
      for (int t = 0; t < 3; t++) begin
         clear_logs();
         start = 1'b1; cfg_s = 5'(cs[t]); cfg_w = 5'(cw[t]);
         @(negedge clk);
         start = 1'b0;
         repeat (3) @(negedge clk);
         checks++;
         if (err_cnt != 1) begin
            errors++;
            $display("[TB] FAIL cfg_err_pulse S=%0d W=%0d: got %0d required 1", cs[t], cw[t], err_cnt);
         end
         checks++;
         if (busy_cnt != 0 || rdy_cnt != 0) begin
            errors++;
            $display("[TB] FAIL cfg_err_idle S=%0d W=%0d: got busy=%0d ready=%0d required 0 0", cs[t], cw[t], busy_cnt, rdy_cnt);
         end
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 5; i++) fbeat[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 12; i++) ibeat[i] = 8'($urandom_range(0, 255));
      run_job(5, 12, 1'b1, 10, 1'b0);
      check_loads(5, 12);
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL bp_done: got %0d required 1", done_cnt);
      end
   endtask

   task automatic test_start_ignored();
      for (int i = 0; i < 3; i++) fbeat[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 8; i++) ibeat[i] = 8'($urandom_range(0, 255));
      run_job(3, 8, 1'b0, 0, 1'b1);
      checks++;
      if (en_cnt != 18) begin
         errors++;
         $display("[TB] FAIL poke_issues: got %0d required 18", en_cnt);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL poke_done: got %0d required 1", done_cnt);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; cfg_s = 5'd0; cfg_w = 5'd0;
      in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b1;
      clear_logs();
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_hazard();
      test_invalid();
      test_backpressure();
      test_start_ignored();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
